// File: rtl/barrel_shifter_arbiter.sv
// Round-robin front end that shares one external barrel_shifter between N
// requesters. S1 holds the granted operand and drives the shifter; S2 captures
// the shifter result and presents it on rsp_*.

// Per-requester lane: flags a valid request at or above the round-robin pointer.
module bsa_lane #(
    parameter int LOG2N = 2,
    parameter int IDX   = 0
) (
    input  logic             valid,
    input  logic [LOG2N-1:0] rr_ptr,
    output logic             hi
);
    assign hi = valid && (int'(rr_ptr) <= IDX);
endmodule

module barrel_shifter_arbiter #(
    parameter int W     = 64,
    parameter int LOG2W = 6,
    parameter int N     = 4,
    parameter int LOG2N = 2
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N-1:0]       req_dir,
    input  logic [N-1:0]       req_op,
    input  logic [N-1:0]       req_shift_t,
    input  logic [N*LOG2W-1:0] req_sel,
    input  logic [N*W-1:0]     req_data,
    output logic               bs_dir,
    output logic               bs_op,
    output logic               bs_shift_t,
    output logic [LOG2W-1:0]   bs_sel,
    output logic [W-1:0]       bs_in,
    input  logic [W-1:0]       bs_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [LOG2N-1:0]   rsp_id,
    output logic [W-1:0]       rsp_data
);
    localparam int STAGES = 2;

    // vld_pipe[0] is this cycle's accept, [1] is S1 valid, [2] is S2 valid
    logic [STAGES:0]             vld_pipe;
    logic [N-1:0]                hi_mask;
    logic [LOG2N-1:0]            rr_ptr;
    logic [LOG2N-1:0]            gnt_idx;
    logic                        gnt_any;
    logic                        adv1;
    logic                        adv2;
    logic [LOG2N-1:0]            s1_id;
    logic [N-1:0][W-1:0]         data_a;
    logic [N-1:0][LOG2W-1:0]     sel_a;

    assign data_a = req_data;
    assign sel_a  = req_sel;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_lane
            bsa_lane #(.LOG2N(LOG2N), .IDX(k)) u_lane (
                .valid  (req_valid[k]),
                .rr_ptr (rr_ptr),
                .hi     (hi_mask[k])
            );
        end
    endgenerate

    // S2 moves when empty or drained; S1 moves when empty or S2 moves
    assign adv2 = !vld_pipe[2] || rsp_ready;
    assign adv1 = !vld_pipe[1] || adv2;

    // Lowest valid at/above rr_ptr wins; otherwise wrap to the lowest valid overall
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_idx = LOG2N'(i);
                gnt_any = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (hi_mask[i]) gnt_idx = LOG2N'(i);
        end
    end

    // One-hot ready toward the winner, gated by S1 being able to take it
    always_comb begin
        req_ready          = '0;
        req_ready[gnt_idx] = adv1 && gnt_any;
    end

    assign vld_pipe[0] = adv1 && gnt_any;

    // S1 operand register and round-robin pointer
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_id       <= '0;
            rr_ptr      <= '0;
            bs_dir      <= 1'b0;
            bs_op       <= 1'b0;
            bs_shift_t  <= 1'b0;
            bs_sel      <= '0;
            bs_in       <= '0;
        end else if (adv1) begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                s1_id      <= gnt_idx;
                rr_ptr     <= (gnt_idx == LOG2N'(N - 1)) ? '0 : gnt_idx + LOG2N'(1);
                bs_dir     <= req_dir[gnt_idx];
                bs_op      <= req_op[gnt_idx];
                bs_shift_t <= req_shift_t[gnt_idx];
                bs_sel     <= sel_a[gnt_idx];
                bs_in      <= data_a[gnt_idx];
            end
        end
    end

    // S2 result register captures the shifter output
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_pipe[2] <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                rsp_id   <= s1_id;
                rsp_data <= bs_out;
            end
        end
    end

    assign rsp_valid = vld_pipe[2];

endmodule
